// File: rtl/serial_cla_adder.sv
// Nibble-serial WIDTH-bit adder built around a single 4-bit lookahead slice.
// Contains laca_4_bit (combinational slice) and serial_cla_adder (top).

module laca_4_bit (
  input  logic [3:0] n1,
  input  logic [3:0] n2,
  input  logic       c0,
  output logic [3:0] sum,
  output logic       carry
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate with fully expanded lookahead carries
  always_comb begin
    g    = n1 & n2;
    p    = n1 ^ n2;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    sum   = p ^ c[3:0];
    carry = c[4];
  end

endmodule

module serial_cla_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  input  logic             c0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             cin;
  logic [IW-1:0]    idx;
  logic [3:0]       s_sum;
  logic             s_carry;
  logic             last;
  logic             accept;
  logic             c_msb;

  laca_4_bit u_slice (
    .n1    (a_sh[3:0]),
    .n2    (b_sh[3:0]),
    .c0    (cin),
    .sum   (s_sum),
    .carry (s_carry)
  );

  assign last   = (state == RUN) && (idx == LAST);
  assign accept = start && ((state == IDLE) || (state == DONE));
  // Carry into the MSB recovered from the top bit's operands and sum
  assign c_msb  = a_sh[3] ^ b_sh[3] ^ s_sum[3];

  // Status flags decoded from the state register only
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, nibble stepping and result assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      cin      <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh     <= n1;
      b_sh     <= n2;
      cin      <= c0;
      idx      <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN) begin
      for (int unsigned i = 0; i < NIB; i++) begin
        if (idx == IW'(i)) sum[4*i +: 4] <= s_sum;
      end
      a_sh <= a_sh >> 4;
      b_sh <= b_sh >> 4;
      cin  <= s_carry;
      if (last) begin
        idx      <= '0;
        carry    <= s_carry;
        overflow <= s_carry ^ c_msb;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: doc/serial_cla_adder.md
# serial_cla_adder

Multi-cycle WIDTH-bit adder that feeds one nibble per clock through a single instance of the team's 4-bit lookahead slice, `laca_4_bit`. It registers the slice's carry-out as the next nibble's carry-in. It sits directly upstream of `laca_4_bit`: it captures wide operands, drives the slice's `n1`/`n2`/`c0` inputs, and assembles `sum`/`carry` into a registered result. It trades latency for area when a full-width lookahead tree is not wanted.

## Interface
- `WIDTH`, default 16: operand width. Must be a multiple of 4 and at least 4. NIB = WIDTH/4 is the number of nibble steps.
- `clk` input 1: the only clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request an add. Sampled on the rising edge.
- `n1` input WIDTH: operand A. Sampled only on the edge that accepts `start`.
- `n2` input WIDTH: operand B. Sampled only on the edge that accepts `start`.
- `c0` input 1: carry-in. Sampled only on the edge that accepts `start`.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse; result is valid.
- `sum` output WIDTH: registered result.
- `carry` output 1: carry-out of bit WIDTH-1.
- `overflow` output 1: two's-complement overflow.

## Operation
- There are three states: IDLE, RUN, and DONE. Reset forces IDLE.
- Transitions:
  - IDLE with `start`=1 goes to RUN.
  - RUN at nibble index NIB-1 goes to DONE.
  - DONE with `start`=1 goes to RUN.
  - DONE with `start`=0 goes to IDLE.
- In RUN, `start` is ignored. No queuing. Input operands may change freely.
- Accepting edge:
  - Latch `n1`, `n2` into shift registers.
  - Load the carry register with `c0`.
  - Clear `sum`, `carry`, and `overflow` to 0.
  - Set nibble index to 0.
- RUN edge i (i = 0..NIB-1):
  - The slice sees the low nibbles of the shift registers and the carry register.
  - The slice `sum` is written to `sum[4i+3:4i]`.
  - The slice `carry` is written to the carry register.
  - The shift registers shift right by 4 and the index increments.
- Last RUN edge (i = NIB-1):
  - Also write `carry` = slice carry-out.
  - Write `overflow` = slice carry-out XOR carry-into-MSB.
  - Compute carry-into-MSB as `n1[msb]^n2[msb]^sum[msb]` from the latched top nibble.
- Arithmetic: {`carry`,`sum`} = `n1` + `n2` + `c0`, modulo 2^(WIDTH+1). There is no saturation.
- `sum` is partial and not meaningful during RUN. It holds its final value from the DONE cycle until the next accepting edge.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `carry`=0, `overflow`=0, state IDLE, index 0.
- Reset is asynchronous. Asserting `rst_n` mid-RUN aborts immediately: all outputs go to reset values and no `done` is issued.
- Let E0 be the accepting edge.
  - `busy` rises after E0.
  - RUN edges are E1..E_NIB.
  - After E_NIB: `busy`=0, `done`=1, and the result is valid.
  - For WIDTH=16, `done` is visible 4 cycles after E0.
- `done` is high for exactly one cycle unless `start`=1 in the DONE cycle. In that case the next operation is accepted on that edge: `done` drops and `busy` rises, with back-to-back throughput of one result per NIB+1 cycles.
- There is no combinational path from inputs to outputs.
- The slice is purely combinational. The critical path is shift-register to slice to `sum`/carry register.

## Test plan
- WIDTH=16, `n1`=0x1234, `n2`=0x4321, `c0`=0, `start` pulse -> `busy` high for 4 cycles, then `done`=1 with `sum`=0x5555, `carry`=0, `overflow`=0.
- `n1`=0xFFFF, `n2`=0x0001, `c0`=0 -> `sum`=0x0000, `carry`=1, `overflow`=0. The carry must ripple through all 4 nibble steps. Repeat with `n2`=0x0000, `c0`=1 for the same result.
- `n1`=0x7FFF, `n2`=0x0001 -> `sum`=0x8000, `carry`=0, `overflow`=1. Then `n1`=0x8000, `n2`=0x8000 -> `sum`=0x0000, `carry`=1, `overflow`=1.
- `start` held high with changing operands during RUN -> the result matches only the operands latched at E0. In the DONE cycle with `start`=1 and 0x0001+0x0002, a second `done` comes 5 cycles after the first with `sum`=0x0003.
- Deassert `rst_n` two cycles after E0, then release -> `busy`, `done`, `sum`, `carry`, and `overflow` are all 0 immediately. No `done` is issued. The next `start` runs normally.
- WIDTH=4 instance, 0xF+0x1+`c0`=1 -> `done` 1 cycle after E0 with `sum`=0x1, `carry`=1. Plus 1000 random operand/`c0` triples at WIDTH=16 checked against a behavioural `n1`+`n2`+`c0`.
